// File: rtl/uart_prog_pkg.sv
// Shared definitions for the program-load UART receive and transmit paths.
package uart_prog_pkg;
  localparam int UART_DATA_BITS = 8;
  localparam int CPB_W          = 16;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_e;

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_START = START;
  localparam logic [1:0] ST_DATA  = DATA;
  localparam logic [1:0] ST_STOP  = STOP;
endpackage

// File: rtl/prog_byte_fifo.sv
// Small synchronous FIFO; the level counter is one bit wider than the pointers.
module prog_byte_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      level_q;
  logic             do_push;
  logic             do_pop;

  // Full/empty come from the registered level, so a pop never frees a slot in its own cycle.
  assign full    = (level_q == FULL_LVL);
  assign empty   = (level_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];
  assign level   = level_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end
endmodule

// File: rtl/uart_tx_prog.sv
// 8-N-1 UART transmitter with runtime bit period, fed from a small byte FIFO.
module uart_tx_prog
  import uart_prog_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int STOP_BITS  = 1
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [CPB_W-1:0]              clks_per_bit_i,
  input  logic                          tx_valid_i,
  input  logic [UART_DATA_BITS-1:0]     tx_byte_i,
  output logic                          tx_ready_o,
  output logic                          tx_o,
  output logic                          tx_active_o,
  output logic                          frame_done_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);
  localparam logic [2:0] LAST_DATA = 3'(UART_DATA_BITS - 1);
  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

  logic [1:0]                state_q;
  logic [CPB_W-1:0]          cnt_q;
  logic [CPB_W-1:0]          cpb_q;
  logic [2:0]                bit_idx_q;
  logic [UART_DATA_BITS-1:0] shreg_q;
  logic                      tx_q;
  logic                      active_q;

  logic [UART_DATA_BITS-1:0] fifo_rdata;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic                      bit_end;
  logic                      last_stop;
  logic                      pop;

  function automatic logic [CPB_W-1:0] cpb_eff(input logic [CPB_W-1:0] c);
    return (c == '0) ? CPB_W'(1) : c;
  endfunction

  prog_byte_fifo #(
    .WIDTH (UART_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (tx_valid_i),
    .wdata (tx_byte_i),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level_o)
  );

  assign bit_end      = (cnt_q == '0);
  assign last_stop    = (state_q == ST_STOP) && bit_end && (bit_idx_q == LAST_STOP);
  // Popping from STOP chains frames with no idle gap between them.
  assign pop          = ~fifo_empty && ((state_q == ST_IDLE) || last_stop);
  assign tx_ready_o   = ~fifo_full;
  assign tx_o         = tx_q;
  assign tx_active_o  = active_q;
  assign frame_done_o = last_stop;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      tx_q      <= 1'b1;
      active_q  <= 1'b0;
    end else if (pop) begin
      state_q  <= ST_START;
      cnt_q    <= cpb_eff(clks_per_bit_i) - 1'b1;
      tx_q     <= 1'b0;
      active_q <= 1'b1;
    end else if (!bit_end) begin
      cnt_q <= cnt_q - 1'b1;
    end else begin
      case (state_q)
        ST_START: begin
          state_q   <= ST_DATA;
          bit_idx_q <= '0;
          cnt_q     <= cpb_q - 1'b1;
          tx_q      <= shreg_q[0];
        end
        ST_DATA: begin
          cnt_q <= cpb_q - 1'b1;
          if (bit_idx_q == LAST_DATA) begin
            state_q   <= ST_STOP;
            bit_idx_q <= '0;
            tx_q      <= 1'b1;
          end else begin
            bit_idx_q <= bit_idx_q + 1'b1;
            tx_q      <= shreg_q[1];
          end
        end
        ST_STOP: begin
          if (bit_idx_q == LAST_STOP) begin
            state_q  <= ST_IDLE;
            active_q <= 1'b0;
          end else begin
            bit_idx_q <= bit_idx_q + 1'b1;
            cnt_q     <= cpb_q - 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (pop) begin
      shreg_q <= fifo_rdata;
      cpb_q   <= cpb_eff(clks_per_bit_i);
    end else if ((state_q == ST_DATA) && bit_end) begin
      shreg_q <= {1'b0, shreg_q[UART_DATA_BITS-1:1]};
    end
  end
endmodule

// File: tb/tb_uart_tx_prog.sv
// Scoreboard bench: pushes record expected frames; per-unit monitors decode the serial line.
module tb_uart_tx_prog;
  typedef struct {
    logic [7:0] data;
    int         cpb;
    int         sb;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] cpb = 16'd4;
  logic        valid0 = 1'b0;
  logic        valid1 = 1'b0;
  logic [7:0]  tx_byte = 8'h00;
  logic [1:0]  rdy_w, tx_w, act_w, done_w;
  logic [2:0]  lvl0, lvl1;

  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  bit   mon_en = 1'b0;
  bit   abort [2] = '{1'b0, 1'b0};
  exp_t exp_q0[$], exp_q1[$];
  int   starts0[$], starts1[$];

  uart_tx_prog #(.FIFO_DEPTH(4), .STOP_BITS(1)) dut0 (
    .clk_i(clk), .rst_i(rst), .clks_per_bit_i(cpb), .tx_valid_i(valid0), .tx_byte_i(tx_byte),
    .tx_ready_o(rdy_w[0]), .tx_o(tx_w[0]), .tx_active_o(act_w[0]), .frame_done_o(done_w[0]),
    .fifo_level_o(lvl0));

  uart_tx_prog #(.FIFO_DEPTH(4), .STOP_BITS(2)) dut1 (
    .clk_i(clk), .rst_i(rst), .clks_per_bit_i(cpb), .tx_valid_i(valid1), .tx_byte_i(tx_byte),
    .tx_ready_o(rdy_w[1]), .tx_o(tx_w[1]), .tx_active_o(act_w[1]), .frame_done_o(done_w[1]),
    .fifo_level_o(lvl1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int u, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s unit%0d cyc %0d: got %0h, expected %0h", name, u, cyc, act, exp);
    end
  endtask

  function automatic int q_size(input int u);
    return (u == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one byte; on acceptance record what the line must later carry.
  task automatic push(input int u, input logic [7:0] b, output int acc);
    int   waited = 0;
    exp_t e;
    tx_byte = b;
    if (u == 0) valid0 = 1'b1; else valid1 = 1'b1;
    while (!rdy_w[u] && waited < 3000) begin
      step();
      waited++;
    end
    if (!rdy_w[u]) begin
      chk("push_timeout", u, rdy_w[u], 1);
    end else begin
      step();
      e.data = b;
      e.cpb  = int'(cpb);
      e.sb   = (u == 0) ? 1 : 2;
      if (u == 0) exp_q0.push_back(e); else exp_q1.push_back(e);
    end
    acc = cyc;
    valid0 = 1'b0;
    valid1 = 1'b0;
  endtask

  task automatic wait_active(input int u);
    int t = 0;
    while (!act_w[u] && t < 3000) begin
      step();
      t++;
    end
    chk("active_timeout", u, act_w[u], 1);
  endtask

  task automatic wait_level0();
    int t = 0;
    while ((lvl0 != 0 || lvl1 != 0) && t < 5000) begin
      step();
      t++;
    end
    chk("level_timeout", 0, {lvl1, lvl0}, 0);
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q0.size() != 0 || exp_q1.size() != 0 || act_w != 2'b00) && t < 8000) begin
      step();
      t++;
    end
    chk("drain_timeout", 0, exp_q0.size() + exp_q1.size() + int'(act_w), 0);
    repeat (3) step();
  endtask

  // Reference: start bit, 8 data bits LSB first, sb stop bits, each max(cpb,1) cycles.
  task automatic monitor(input int u);
    exp_t e;
    int   eff, n, idx;
    logic exp_bit;
    wait (mon_en);
    forever begin
      @(negedge clk);
      if (abort[u]) begin
        abort[u] = 1'b0;
        continue;
      end
      if (tx_w[u] !== 1'b0) begin
        chk("idle_active", u, act_w[u], 0);
        chk("idle_done", u, done_w[u], 0);
        continue;
      end
      if (q_size(u) == 0) begin
        chk("unexpected_frame", u, tx_w[u], 1);
        continue;
      end
      if (u == 0) begin
        e = exp_q0.pop_front();
        starts0.push_back(cyc);
      end else begin
        e = exp_q1.pop_front();
        starts1.push_back(cyc);
      end
      eff = (e.cpb == 0) ? 1 : e.cpb;
      n   = (9 + e.sb) * eff;
      for (int k = 0; k < n; k++) begin
        if (k > 0) begin
          @(negedge clk);
          if (abort[u]) begin
            abort[u] = 1'b0;
            break;
          end
        end
        idx = k / eff;
        if (idx == 0)      exp_bit = 1'b0;
        else if (idx <= 8) exp_bit = e.data[idx-1];
        else               exp_bit = 1'b1;
        chk("tx_line", u, tx_w[u], exp_bit);
        chk("tx_active", u, act_w[u], 1);
        chk("frame_done", u, done_w[u], (k == n - 1));
      end
    end
  endtask

  initial monitor(0);
  initial monitor(1);

  initial begin
    int c[6];
    int a;
    int base;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int u = 0; u < 2; u++) begin
      chk("rst_tx", u, tx_w[u], 1);
      chk("rst_active", u, act_w[u], 0);
      chk("rst_done", u, done_w[u], 0);
      chk("rst_ready", u, rdy_w[u], 1);
    end
    chk("rst_level", 0, {lvl1, lvl0}, 0);
    mon_en = 1'b1;
    step();

    // Single 0xA5 frame at 4 cycles per bit.
    cpb = 16'd4;
    push(0, 8'hA5, a);
    drain();

    // Four back-to-back frames at 2 cycles per bit.
    cpb  = 16'd2;
    base = starts0.size();
    push(0, 8'h00, c[0]);
    push(0, 8'hFF, c[1]);
    push(0, 8'h55, c[2]);
    push(0, 8'h3C, c[3]);
    chk("t2_level", 0, lvl0, 3);
    drain();
    for (int i = 1; i < 4; i++)
      chk("t2_gap", 0, starts0[base+i] - starts0[base+i-1], 20);

    // Valid held high for six bytes: five go in, the sixth waits for the next pop.
    for (int i = 0; i < 5; i++) push(0, 8'(8'h10 + i), c[i]);
    chk("t3_burst", 0, c[4] - c[0], 4);
    chk("t3_level", 0, lvl0, 4);
    chk("t3_ready", 0, rdy_w[0], 0);
    push(0, 8'h15, c[5]);
    chk("t3_held", 0, c[5] - c[0], 22);
    drain();

    // cpb=0 acts as 1; cpb change mid-frame applies to the next frame only.
    cpb = 16'd0;
    push(0, 8'h96, a);
    drain();
    cpb  = 16'd8;
    base = starts0.size();
    push(0, 8'hC3, a);
    wait_active(0);
    cpb = 16'd3;
    push(0, 8'h5A, a);
    drain();
    chk("t4_gap", 0, starts0[base+1] - starts0[base], 80);

    // Two stop bits at cpb=5: 55-cycle frame pitch.
    cpb  = 16'd5;
    base = starts1.size();
    push(1, 8'h81, a);
    push(1, 8'h7E, a);
    drain();
    chk("t6_gap", 1, starts1[base+1] - starts1[base], 55);

    // Reset in the middle of data bit 3 with two bytes still queued.
    cpb = 16'd4;
    push(0, 8'hE7, a);
    push(0, 8'h11, a);
    push(0, 8'h22, a);
    wait_active(0);
    repeat (15) step();
    abort[0] = 1'b1;
    abort[1] = 1'b1;
    exp_q0.delete();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t5_tx", 0, tx_w[0], 1);
    chk("t5_active", 0, act_w[0], 0);
    chk("t5_level", 0, lvl0, 0);
    chk("t5_ready", 0, rdy_w[0], 1);
    chk("t5_done", 0, done_w[0], 0);
    repeat (100) step();

    // Random bytes, units, gaps and bit periods.
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        wait_level0();
        cpb = 16'($urandom_range(0, 5));
      end
      push(int'($urandom_range(0, 1)), 8'($urandom), a);
      repeat ($urandom_range(0, 3)) step();
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
